// File: rtl/fmul_share_ctrl.sv
// fmul_share_ctrl: round-robin sharing of one fixed-latency FP multiplier among NUM_REQ requesters
module fmul_share_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 8,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [32*NUM_REQ-1:0]    req_a,
   input  logic [32*NUM_REQ-1:0]    req_b,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [31:0]              rsp_z,
   output logic                     mul_rst,
   output logic [31:0]              mul_a,
   output logic [31:0]              mul_b,
   input  logic [31:0]              mul_z,
   output logic                     busy,
   output logic [CNT_W-1:0]         op_count
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(MUL_LATENCY) + 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
   localparam logic [WW-1:0] WAIT_END = WW'(MUL_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t state, state_nx;
   logic [IW-1:0] last_grant, grant, cur;
   logic found;
   logic [WW-1:0] wait_cnt;

   // round-robin pick: scanning downward lets the nearest index after last_grant win
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_valid[IW'((int'(last_grant) + k) % NUM_REQ)]) begin
            grant = IW'((int'(last_grant) + k) % NUM_REQ);
            found = 1'b1;
         end
      end
   end

   // next-state sequencing of one multiply at a time
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = found ? LAUNCH : IDLE;
         LAUNCH:  state_nx = WAIT;
         WAIT:    state_nx = (wait_cnt == WAIT_END) ? RESP : WAIT;
         RESP:    state_nx = rsp_ready[cur] ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << grant) : '0;
   assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << cur) : '0;
   assign mul_rst   = (state != WAIT);
   assign busy      = (state != IDLE);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // operand latch, latency timer, result capture and completion bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a      <= '0;
         mul_b      <= '0;
         cur        <= '0;
         last_grant <= LAST_RST;
         wait_cnt   <= '0;
         rsp_z      <= '0;
         op_count   <= '0;
      end else begin
         if (state == IDLE && found) begin
            mul_a <= req_a[{grant, 5'd0} +: 32];
            mul_b <= req_b[{grant, 5'd0} +: 32];
            cur   <= grant;
         end
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (state == WAIT && wait_cnt == WAIT_END) rsp_z <= mul_z;
         if (state == RESP && rsp_ready[cur]) begin
            last_grant <= cur;
            op_count   <= op_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fmul_share_ctrl.sv
// tb_fmul_share_ctrl: transaction-level model plus directed scenarios for the shared multiplier controller
module tb_fmul_share_ctrl;
   localparam int N = 4;
   localparam int L = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req_valid = '0, rsp_ready = '0;
   logic [32*N-1:0] req_a = '0, req_b = '0;
   logic [N-1:0] req_ready, rsp_valid;
   logic [31:0] rsp_z, mul_a, mul_b, mul_z;
   logic mul_rst, busy;
   logic [15:0] op_count;

   fmul_share_ctrl #(.NUM_REQ(N), .MUL_LATENCY(L), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_z(rsp_z), .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
      .mul_z(mul_z), .busy(busy), .op_count(op_count));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   int pend [N];
   int grants [$];
   logic [N-1:0] acc_mask = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // hand-computed products for every operand pair used below
   function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40000000;
         {32'h3FC00000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'h40400000}: return 32'h41100000;
         {32'hC0000000, 32'h3F000000}: return 32'hBF800000;
         {32'h40800000, 32'h3E800000}: return 32'h3F800000;
         {32'h7F800000, 32'h00000000}: return 32'hFFC00000;
         {32'h7F000000, 32'h7F000000}: return 32'h7F800000;
         default: return a ^ b;
      endcase
   endfunction

   // multiplier stand-in: garbage until L clocks after its reset drops
   int mcnt = 0;
   always @(posedge clk) mcnt <= mul_rst ? 0 : mcnt + 1;
   assign mul_z = (!mul_rst && mcnt >= L - 1) ? prod(mul_a, mul_b) : 32'hDEADBEEF;

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] r;
      r = '0;
      if (i >= 0) r[i] = 1'b1;
      return r;
   endfunction

   // transaction model: age counts edges since the accepting edge
   logic m_busy = 1'b0;
   int m_owner = 0, m_age = 0, m_last = N - 1;
   logic [15:0] m_cnt = '0;
   logic [31:0] m_a = '0, m_b = '0, m_z = '0, m_res = '0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_age <= 0; m_last <= N - 1; m_cnt <= '0;
         m_a <= '0; m_b <= '0; m_z <= '0; m_owner <= 0;
      end else if (!m_busy) begin
         if (pick(req_valid, m_last) >= 0) begin
            m_busy  <= 1'b1;
            m_owner <= pick(req_valid, m_last);
            m_age   <= 0;
            m_a     <= req_a[32*pick(req_valid, m_last) +: 32];
            m_b     <= req_b[32*pick(req_valid, m_last) +: 32];
            m_res   <= prod(req_a[32*pick(req_valid, m_last) +: 32], req_b[32*pick(req_valid, m_last) +: 32]);
         end
      end else if (m_age >= L + 1) begin
         if (rsp_ready[m_owner]) begin
            m_busy <= 1'b0;
            m_last <= m_owner;
            m_cnt  <= m_cnt + 16'd1;
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age + 1 == L + 1) m_z <= m_res;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // per-cycle comparison against the model, plus grant logging
   always @(negedge clk) begin
      if (!rst) begin
         chk("req_ready", 32'(req_ready), 32'(m_busy ? '0 : onehot(pick(req_valid, m_last))));
         chk("rsp_valid", 32'(rsp_valid), 32'((m_busy && m_age >= L + 1) ? onehot(m_owner) : '0));
         chk("rsp_z", rsp_z, m_z);
         chk("mul_rst", 32'(mul_rst), 32'(!m_busy || m_age == 0 || m_age >= L + 1));
         chk("mul_a", mul_a, m_a);
         chk("mul_b", mul_b, m_b);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("op_count", 32'(op_count), 32'(m_cnt));
         acc_mask <= req_valid & req_ready;
         for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) grants.push_back(i);
      end else acc_mask <= '0;
   end

   task automatic step();
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) if (acc_mask[i]) begin
         pend[i]--;
         if (pend[i] == 0) req_valid[i] = 1'b0;
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input int n);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      pend[i] = n;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_rr(input int i, output int acc);
      acc = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            acc = cyc + 1;
            step();
            return;
         end
         step();
      end
      errors++; checks++;
      $display("FAIL timeout_req_ready%0d", i);
   endtask

   task automatic wait_rv(input int i);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rsp_valid[i]) return;
         step();
      end
      errors++; checks++;
      $display("FAIL timeout_rsp_valid%0d", i);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!busy && pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0) return;
         step();
      end
      errors++; checks++;
      $display("FAIL timeout_idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, gb;
      logic [31:0] prod_chk;
      for (int i = 0; i < N; i++) pend[i] = 0;
      prod_chk = prod(32'h7F800000, 32'h00000000);
      chk("model_inf_zero", prod_chk, 32'hFFC00000);
      // reset values
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_mul_rst", 32'(mul_rst), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_op_count", 32'(op_count), 0);
      chk("rst_rsp_z", rsp_z, 0);
      step(); rst = 1'b0;
      rsp_ready = '1;
      // single request and its latency
      set_op(0, 32'h3F800000, 32'h40000000, 1);
      wait_rr(0, acc);
      wait_rv(0);
      chk("single_latency", 32'(cyc - acc), 9);
      chk("single_z", rsp_z, 32'h40000000);
      step();
      chk("single_count", 32'(op_count), 1);
      rst = 1'b1; step(); step(); rst = 1'b0;
      // contention from reset
      gb = grants.size();
      set_op(0, 32'h3FC00000, 32'h40000000, 1);
      set_op(1, 32'h40400000, 32'h40400000, 1);
      set_op(2, 32'hC0000000, 32'h3F000000, 1);
      set_op(3, 32'h40800000, 32'h3E800000, 1);
      wait_rv(0); chk("cont_z0", rsp_z, 32'h40400000); step();
      wait_rv(1); chk("cont_z1", rsp_z, 32'h41100000); step();
      wait_rv(2); chk("cont_z2", rsp_z, 32'hBF800000); step();
      wait_rv(3); chk("cont_z3", rsp_z, 32'h3F800000); step();
      for (int k = 0; k < 4; k++) chk("cont_grant", (grants.size() > gb + k) ? 32'(grants[gb+k]) : 32'hFFFFFFFF, 32'(k));
      // fairness between requesters 1 and 3
      gb = grants.size();
      set_op(1, 32'h3F800000, 32'h40000000, 2);
      wait_rr(1, acc);
      set_op(3, 32'hC0000000, 32'h3F000000, 2);
      wait_idle(); step();
      chk("fair_g0", (grants.size() > gb) ? 32'(grants[gb]) : 32'hFFFFFFFF, 1);
      chk("fair_g1", (grants.size() > gb + 1) ? 32'(grants[gb+1]) : 32'hFFFFFFFF, 3);
      chk("fair_g2", (grants.size() > gb + 2) ? 32'(grants[gb+2]) : 32'hFFFFFFFF, 1);
      chk("fair_g3", (grants.size() > gb + 3) ? 32'(grants[gb+3]) : 32'hFFFFFFFF, 3);
      // special operands
      set_op(0, 32'h7F800000, 32'h00000000, 1);
      wait_rv(0); chk("inf_times_zero", rsp_z, 32'hFFC00000); step();
      set_op(1, 32'h7F000000, 32'h7F000000, 1);
      wait_rv(1); chk("overflow", rsp_z, 32'h7F800000); step();
      // backpressure on requester 2 with requester 0 pending
      rsp_ready[2] = 1'b0;
      set_op(2, 32'h40400000, 32'h40400000, 1);
      wait_rv(2); step();
      set_op(0, 32'h3FC00000, 32'h40000000, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_req_ready", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
         chk("bp_rsp_z", rsp_z, 32'h41100000);
         chk("bp_count", 32'(op_count), 10);
         step();
      end
      rsp_ready[2] = 1'b1;
      wait_rv(0); chk("bp_next_z", rsp_z, 32'h40400000); step();
      chk("bp_count_after", 32'(op_count), 12);
      set_op(2, 32'hC0000000, 32'h3F000000, 1);
      wait_rv(2); step();
      // abort during WAIT, then the pointer restarts at requester 0
      set_op(2, 32'h40800000, 32'h3E800000, 1);
      wait_rr(2, acc);
      for (int k = 0; k < 5; k++) step();
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_mul_rst", 32'(mul_rst), 1);
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
      chk("abort_op_count", 32'(op_count), 0);
      chk("abort_mul_a", mul_a, 0);
      chk("abort_rsp_z", rsp_z, 0);
      set_op(2, 32'h3FC00000, 32'h40000000, 1);
      set_op(3, 32'h7F000000, 32'h7F000000, 1);
      step(); step(); rst = 1'b0;
      gb = grants.size();
      wait_rv(2); chk("post_rst_z2", rsp_z, 32'h40400000); step();
      chk("post_rst_first", (grants.size() > gb) ? 32'(grants[gb]) : 32'hFFFFFFFF, 2);
      wait_rv(3); chk("post_rst_z3", rsp_z, 32'h7F800000); step();
      chk("post_rst_count", 32'(op_count), 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
